// File: rtl/fifo_adc_pkg.sv
// Width-derivation helpers shared by the tagged ADC sample FIFO and its RAM.
package fifo_adc_pkg;

    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Occupancy must reach DEPTH itself, so one more state than the pointer range.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2_min1(depth);
    endfunction

    function automatic int entry_width(input int data_width, input int num_ch);
        return data_width + clog2_min1(num_ch);
    endfunction

    function automatic bit is_pow2_ge4(input int n);
        return (n >= 4) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_adc_tagged_dpram.sv
// Simple dual-port RAM: synchronous write, registered read with read enable.
// The read register resets to zero and holds its value whenever no read is issued.
module fifo_adc_tagged_dpram #(
    parameter int WIDTH  = 18,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write: a same-address write this edge is seen on the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fifo_adc_tagged.sv
// Tagged ADC sample FIFO: exact count, thresholds, sticky errors, sync flush.
// Optional FIFO_ADC_WATERMARK_EN adds max_count, the peak occupancy since reset/clr.
module fifo_adc_tagged
    import fifo_adc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 128,
    parameter int AF_THRESH  = 96,
    parameter int AE_THRESH  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr,
    input  logic                                 wr_en,
    input  logic [DATA_WIDTH-1:0]                adc_data_in,
    input  logic [clog2_min1(NUM_CH)-1:0]        adc_ch_in,
    input  logic                                 rd_en,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic [clog2_min1(NUM_CH)-1:0]        ch_out,
    output logic                                 data_valid,
    output logic [cnt_width(DEPTH)-1:0]          count,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 almost_full,
    output logic                                 almost_empty,
    output logic                                 overflow,
    output logic                                 underflow
`ifdef FIFO_ADC_WATERMARK_EN
    ,
    output logic [cnt_width(DEPTH)-1:0]          max_count
`endif
);

    localparam int CH_W  = clog2_min1(NUM_CH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int ENT_W = entry_width(DATA_WIDTH, NUM_CH);

    generate
        if (!is_pow2_ge4(DEPTH)) begin : g_bad_depth
            $error("fifo_adc_tagged: DEPTH must be a power of two >= 4");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("fifo_adc_tagged: AF_THRESH out of range 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("fifo_adc_tagged: AE_THRESH out of range 0..DEPTH-1");
        end
    endgenerate

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_full;
    logic             r_empty;
    logic             r_af;
    logic             r_ae;
    logic             r_ovf;
    logic             r_unf;
    logic             r_dv;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [ENT_W-1:0] w_wr_entry;
    logic [ENT_W-1:0] w_rd_entry;

    // A full FIFO still takes a write when a read frees a slot on the same edge.
    always_comb begin
        w_rd_acc  = rd_en & ~r_empty & ~clr;
        w_wr_acc  = wr_en & (~r_full | w_rd_acc) & ~clr;
        w_cnt_nxt = r_count;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_count + CNT_W'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_cnt_nxt = r_count - CNT_W'(1);
        end
    end

    assign w_wr_entry = {adc_ch_in, adc_data_in};

    fifo_adc_tagged_dpram #(
        .WIDTH  (ENT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    // Flags come from the next count so they match occupancy right after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= 1'b0;
            r_ae     <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_dv     <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
            r_af    <= (w_cnt_nxt >= CNT_W'(AF_THRESH));
            r_ae    <= (w_cnt_nxt <= CNT_W'(AE_THRESH));
            r_dv    <= w_rd_acc;
            if (clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_ovf    <= 1'b0;
                r_unf    <= 1'b0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (wr_en && !w_wr_acc) begin
                    r_ovf <= 1'b1;
                end
                if (rd_en && r_empty) begin
                    r_unf <= 1'b1;
                end
            end
        end
    end

`ifdef FIFO_ADC_WATERMARK_EN
    logic [CNT_W-1:0] r_max_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_count <= '0;
        end else if (clr) begin
            r_max_count <= '0;
        end else if (w_cnt_nxt > r_max_count) begin
            r_max_count <= w_cnt_nxt;
        end
    end

    assign max_count = r_max_count;
`endif

    assign {ch_out, data_out} = w_rd_entry;
    assign data_valid   = r_dv;
    assign count        = r_count;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;

endmodule

// File: tb/tb_fifo_adc_tagged.sv
// Bench for fifo_adc_tagged: queue-based reference model, per-cycle compare, directed + random stimulus.
// Covers max_count when FIFO_ADC_WATERMARK_EN is defined.
module tb_fifo_adc_tagged;

    localparam int DW  = 12;
    localparam int NCH = 4;
    localparam int DEP = 8;
    localparam int AF  = 6;
    localparam int AE  = 1;
    localparam int CW  = 2;
    localparam int NW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] adc_data_in = '0;
    logic [CW-1:0] adc_ch_in = '0;
    logic [DW-1:0] data_out;
    logic [CW-1:0] ch_out;
    logic          data_valid;
    logic [NW-1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;
`ifdef FIFO_ADC_WATERMARK_EN
    logic [NW-1:0] max_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DW+CW-1:0] m_q[$];
    logic [DW-1:0]    m_dout = '0;
    logic [CW-1:0]    m_ch = '0;
    bit               m_dv = 1'b0;
    bit               m_ovf = 1'b0;
    bit               m_unf = 1'b0;
    int               m_peak = 0;

    fifo_adc_tagged #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .DEPTH      (DEP),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wr_en        (wr_en),
        .adc_data_in  (adc_data_in),
        .adc_ch_in    (adc_ch_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .ch_out       (ch_out),
        .data_valid   (data_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_ADC_WATERMARK_EN
        ,
        .max_count    (max_count)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pop before push, so a full FIFO can take a write with a read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_dout = '0;
            m_ch   = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_peak = 0;
        end else if (clr) begin
            m_q.delete();
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_peak = 0;
        end else begin
            bit rd_ok;
            bit wr_ok;
            logic [DW+CW-1:0] e;
            rd_ok = rd_en && (m_q.size() > 0);
            wr_ok = wr_en && ((m_q.size() < DEP) || rd_ok);
            m_dv  = rd_ok;
            if (rd_ok) begin
                e = m_q.pop_front();
                m_ch   = e[DW+CW-1:DW];
                m_dout = e[DW-1:0];
            end
            if (wr_ok) m_q.push_back({adc_ch_in, adc_data_in});
            if (wr_en && !wr_ok) m_ovf = 1'b1;
            if (rd_en && !rd_ok) m_unf = 1'b1;
            if (m_q.size() > m_peak) m_peak = m_q.size();
        end
    end

    // Scoreboard compare, every cycle, away from the active edge
    always @(negedge clk) begin
        chk("count", 32'(count), m_q.size());
        chk("full", 32'(full), 32'(m_q.size() == DEP));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("almost_full", 32'(almost_full), 32'(m_q.size() >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(m_q.size() <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("data_valid", 32'(data_valid), 32'(m_dv));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("ch_out", 32'(ch_out), 32'(m_ch));
`ifdef FIFO_ADC_WATERMARK_EN
        chk("max_count", 32'(max_count), m_peak);
`endif
    end

    // Driver: apply inputs for one clock, return at the following falling edge
    task automatic cyc(input bit w, input int d, input int c, input bit r, input bit cl);
        wr_en = w;
        adc_data_in = DW'(d);
        adc_ch_in = CW'(c);
        rd_en = r;
        clr = cl;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(count), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_ae"}, 32'(almost_empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_af"}, 32'(almost_full), 0);
        chk({tag, "_dv"}, 32'(data_valid), 0);
        chk({tag, "_data"}, 32'(data_out), 0);
        chk({tag, "_ch"}, 32'(ch_out), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_unf"}, 32'(underflow), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then one write too many
        for (int i = 0; i < 8; i++) begin
            cyc(1, 'h100 + i, i % 4, 0, 0);
            if (i == 0) chk("ae_after1", 32'(almost_empty), 1);
            if (i == 1) chk("ae_after2", 32'(almost_empty), 0);
            if (i == 4) chk("af_after5", 32'(almost_full), 0);
            if (i == 5) chk("af_after6", 32'(almost_full), 1);
            if (i == 6) chk("full_after7", 32'(full), 0);
        end
        chk("full_after8", 32'(full), 1);
        chk("count_after8", 32'(count), 8);
        cyc(1, 'h1FF, 0, 0, 0);
        chk("ovf_9th", 32'(overflow), 1);
        chk("count_9th", 32'(count), 8);
`ifdef FIFO_ADC_WATERMARK_EN
        chk("max_after_full", 32'(max_count), 8);
`endif

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("rd_dv", 32'(data_valid), 1);
            chk("rd_data", 32'(data_out), 'h100 + i);
            chk("rd_ch", 32'(ch_out), i % 4);
        end
        chk("empty_after8rd", 32'(empty), 1);
        cyc(0, 0, 0, 0, 0);
        chk("idle_dv", 32'(data_valid), 0);
        chk("idle_hold", 32'(data_out), 'h107);

        // Full with simultaneous read and write
        cyc(0, 0, 0, 0, 1);
        chk("clr_ovf", 32'(overflow), 0);
        for (int i = 0; i < 8; i++) cyc(1, 'h200 + i, i % 4, 0, 0);
        cyc(1, 'h2AA, 2, 1, 0);
        chk("rw_full_count", 32'(count), 8);
        chk("rw_full_ovf", 32'(overflow), 0);
        chk("rw_full_data", 32'(data_out), 'h200);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0);
            chk("wrap_data", 32'(data_out), 'h200 + i);
        end
        cyc(0, 0, 0, 1, 0);
        chk("wrap_last", 32'(data_out), 'h2AA);
        chk("wrap_last_ch", 32'(ch_out), 2);
        chk("wrap_empty", 32'(empty), 1);

        // Empty with simultaneous read and write
        cyc(1, 'h055, 1, 1, 0);
        chk("emp_rw_unf", 32'(underflow), 1);
        chk("emp_rw_dv", 32'(data_valid), 0);
        chk("emp_rw_count", 32'(count), 1);
        cyc(0, 0, 0, 1, 0);
        chk("emp_rw_data", 32'(data_out), 'h055);
        chk("emp_rw_rdv", 32'(data_valid), 1);

        // Flush with count=5 and overflow set; requests during clr are ignored
        for (int i = 0; i < 8; i++) cyc(1, 'h300 + i, i % 4, 0, 0);
        cyc(1, 'h3FE, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
        chk("preclr_count", 32'(count), 5);
        chk("preclr_ovf", 32'(overflow), 1);
`ifdef FIFO_ADC_WATERMARK_EN
        chk("preclr_max", 32'(max_count), 8);
`endif
        cyc(1, 'h3FF, 0, 1, 1);
        chk("clr_count", 32'(count), 0);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_ae", 32'(almost_empty), 1);
        chk("clr_ovf2", 32'(overflow), 0);
        chk("clr_unf", 32'(underflow), 0);
        chk("clr_dv", 32'(data_valid), 0);
        chk("clr_hold", 32'(data_out), 'h302);
`ifdef FIFO_ADC_WATERMARK_EN
        chk("clr_max", 32'(max_count), 0);
`endif

        // Random traffic with alternating fill/drain bias, rare clr, one mid-burst reset
        for (int k = 0; k < 600; k++) begin
            int bias;
            bias = ((k / 60) % 2 == 1) ? 75 : 25;
            if (k == 300) begin
                wr_en = 1'b1;
                adc_data_in = DW'($urandom_range(0, 4095));
                #2 rst_n = 1'b0;
                #1 chk_reset_vals("midrst");
                @(negedge clk);
                wr_en = 1'b0;
                rst_n = 1'b1;
            end
            cyc($urandom_range(0, 99) < bias, $urandom_range(0, 4095), $urandom_range(0, 3),
                $urandom_range(0, 99) < (100 - bias), $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
